// File: rtl/bus_burst_ram_slave.sv
// Burst-capable on-chip RAM slave for the shared DMA bus. It streams read bursts one word
// per cycle and absorbs byte-enabled write bursts. Outputs are zero whenever it is not responding.
module bus_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut
);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ,
        WRITE,
        ERROR
    } StateType;

    localparam logic [31:0]           BaseAddr = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;

    StateType              state;
    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] wordPtr;
    logic [8:0]            remaining;
    logic [31:0]           ramData;
    logic                  selected;
    logic                  writeEnable;

    // The window is aligned to its own size, so decoding only needs the upper address bits.
    always_comb begin
        selected    = (addressDataIn[31:ADDR_WIDTH+2] == BaseAddr[31:ADDR_WIDTH+2]);
        writeEnable = (state == WRITE) && dataValidIn && (remaining != 9'd0);
    end

    // The RAM read port runs every cycle. In READ_WAIT it prefetches the first word.
    // In READ it fetches the next word while the current one is on the bus.
    always_ff @(posedge clock) begin
        if (writeEnable) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEnablesIn[i]) begin
                    mem[wordPtr][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
        ramData <= mem[wordPtr];
    end

    // Control FSM. Outputs default to zero each cycle and are only driven while responding.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            wordPtr           <= '0;
            remaining         <= '0;
            addressDataOut    <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
        end else begin
            addressDataOut    <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (beginTransactionIn && selected) begin
                        wordPtr   <= addressDataIn[ADDR_WIDTH+1:2];
                        remaining <= {1'b0, burstSizeIn} + 9'd1;
                        if (addressDataIn[1:0] != 2'b00) begin
                            state <= ERROR;
                        end else if (readNotWriteIn) begin
                            state <= READ_WAIT;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                READ_WAIT: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else begin
                        wordPtr <= wordPtr + PtrOne;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else if (remaining != 9'd0) begin
                        addressDataOut <= ramData;
                        dataValidOut   <= 1'b1;
                        wordPtr        <= wordPtr + PtrOne;
                        remaining      <= remaining - 9'd1;
                    end else begin
                        endTransactionOut <= 1'b1;
                        state             <= IDLE;
                    end
                end
                WRITE: begin
                    if (writeEnable) begin
                        wordPtr   <= wordPtr + PtrOne;
                        remaining <= remaining - 9'd1;
                    end
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    busErrorOut       <= 1'b1;
                    endTransactionOut <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_burst_ram_slave.sv
// Directed testbench for bus_burst_ram_slave. It checks burst read/write, byte enables,
// window wrap, address decode, error response and master abort.
module tb_bus_burst_ram_slave;

    localparam logic [31:0] Base = 32'h5000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic [7:0]  burstSizeIn = '0;
    logic        readNotWriteIn = 1'b0;
    logic [3:0]  byteEnablesIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] wData [8];
    logic [3:0]  wBe [8];
    logic [31:0] rExp [8];

    bus_burst_ram_slave #(
        .BASE_ADDR (32'h5000_0000),
        .ADDR_WIDTH(10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn    (addressDataIn),
        .burstSizeIn      (burstSizeIn),
        .readNotWriteIn   (readNotWriteIn),
        .byteEnablesIn    (byteEnablesIn),
        .dataValidIn      (dataValidIn),
        .endTransactionIn (endTransactionIn),
        .addressDataOut   (addressDataOut),
        .dataValidOut     (dataValidOut),
        .endTransactionOut(endTransactionOut),
        .busErrorOut      (busErrorOut)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, busErrorOut, endTransactionOut, dataValidOut};
    endfunction

    // Each call steps one edge. Outputs are then sampled and new inputs driven 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] burst, input logic rnw);
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        burstSizeIn        = burst;
        readNotWriteIn     = rnw;
        tick();
        beginTransactionIn = 1'b0;
        addressDataIn      = '0;
        burstSizeIn        = '0;
        readNotWriteIn     = 1'b0;
    endtask

    task automatic writeBurst(input logic [31:0] addr, input int n);
        applyStimulus(addr, 8'(n - 1), 1'b0);
        for (int i = 0; i < n; i++) begin
            dataValidIn   = 1'b1;
            addressDataIn = wData[i];
            byteEnablesIn = wBe[i];
            tick();
        end
        dataValidIn      = 1'b0;
        addressDataIn    = '0;
        byteEnablesIn    = '0;
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
    endtask

    task automatic readBurst(input string tag, input logic [31:0] addr, input int n);
        applyStimulus(addr, 8'(n - 1), 1'b1);
        checkOutput({tag, "_beginCycle"}, flags(), 32'd0);
        tick();
        checkOutput({tag, "_waitCycle"}, flags(), 32'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput($sformatf("%s_flags%0d", tag, i), flags(), 32'd1);
            checkOutput($sformatf("%s_data%0d", tag, i), addressDataOut, rExp[i]);
        end
        tick();
        checkOutput({tag, "_endFlags"}, flags(), 32'd2);
        checkOutput({tag, "_endData"}, addressDataOut, 32'd0);
        tick();
        checkOutput({tag, "_idle"}, flags(), 32'd0);
    endtask

    initial begin
        // Reset with random inputs: outputs must stay quiet.
        for (int c = 0; c < 4; c++) begin
            beginTransactionIn = 1'($urandom_range(0, 1));
            addressDataIn      = $urandom;
            burstSizeIn        = 8'($urandom);
            readNotWriteIn     = 1'($urandom_range(0, 1));
            byteEnablesIn      = 4'($urandom);
            dataValidIn        = 1'($urandom_range(0, 1));
            endTransactionIn   = 1'($urandom_range(0, 1));
            tick();
            checkOutput($sformatf("reset_flags%0d", c), flags(), 32'd0);
            checkOutput($sformatf("reset_data%0d", c), addressDataOut, 32'd0);
        end
        reset              = 1'b0;
        beginTransactionIn = 1'b0;
        addressDataIn      = '0;
        burstSizeIn        = '0;
        readNotWriteIn     = 1'b0;
        byteEnablesIn      = '0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;

        // Four-word burst written right after reset release, then read back.
        wData[0] = 32'd33; wData[1] = 32'd43; wData[2] = 32'd53; wData[3] = 32'd63;
        for (int i = 0; i < 4; i++) wBe[i] = 4'hF;
        writeBurst(Base + 32'h10, 4);
        rExp[0] = 32'd33; rExp[1] = 32'd43; rExp[2] = 32'd53; rExp[3] = 32'd63;
        readBurst("burst4", Base + 32'h10, 4);

        // Byte-enable merge.
        wData[0] = 32'h1122_3344; wBe[0] = 4'hF;
        writeBurst(Base + 32'h20, 1);
        wData[0] = 32'hAABB_CCDD; wBe[0] = 4'b0101;
        writeBurst(Base + 32'h20, 1);
        rExp[0] = 32'h11BB_33DD;
        readBurst("byteEn", Base + 32'h20, 1);

        // Pointer wraps from the last word of the window to word 0.
        wData[0] = 32'h0000_000A; wBe[0] = 4'hF;
        writeBurst(Base + 32'hFFC, 1);
        wData[0] = 32'h0000_000B;
        writeBurst(Base, 1);
        rExp[0] = 32'h0000_000A; rExp[1] = 32'h0000_000B;
        readBurst("wrap", Base + 32'hFFC, 2);

        // Misaligned begin inside the window gives a one-cycle error.
        applyStimulus(Base + 32'h2, 8'd0, 1'b1);
        checkOutput("err_beginCycle", flags(), 32'd0);
        tick();
        checkOutput("err_strobe", flags(), 32'd6);
        checkOutput("err_data", addressDataOut, 32'd0);
        tick();
        checkOutput("err_after", flags(), 32'd0);

        // Addresses just outside the window are ignored.
        applyStimulus(Base - 32'h4, 8'd3, 1'b1);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("below_flags%0d", c), flags(), 32'd0);
            checkOutput($sformatf("below_data%0d", c), addressDataOut, 32'd0);
            tick();
        end
        applyStimulus(Base + 32'h1000, 8'd3, 1'b1);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("above_flags%0d", c), flags(), 32'd0);
            checkOutput($sformatf("above_data%0d", c), addressDataOut, 32'd0);
            tick();
        end

        // Master abort after the third word of an eight-word read.
        for (int i = 0; i < 8; i++) begin
            wData[i] = 32'hC0DE_0000 + 32'(i);
            wBe[i]   = 4'hF;
        end
        writeBurst(Base + 32'h40, 8);
        applyStimulus(Base + 32'h40, 8'd7, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("abort_flags%0d", i), flags(), 32'd1);
            checkOutput($sformatf("abort_data%0d", i), addressDataOut, 32'hC0DE_0000 + 32'(i));
        end
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        checkOutput("abort_flagsAfter", flags(), 32'd0);
        checkOutput("abort_dataAfter", addressDataOut, 32'd0);
        rExp[0] = 32'hC0DE_0000; rExp[1] = 32'hC0DE_0001; rExp[2] = 32'hC0DE_0002;
        readBurst("afterAbort", Base + 32'h40, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
